xifo_ctrl: RTL and testbench

XIFO_CTRL -- requirements
Module: xifo_ctrl

---
 rtl/xifo_ctrl.sv | 173 +++++++++++++++++
 tb/tb_xifo_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xifo_ctrl.sv
// xifo_ctrl: stack/queue controller driving an external single-port-pair RAM
// with registered read data.
//
// MODE=0 behaves as a LIFO stack (single pointer), MODE=1 as a FIFO queue
// (separate write/read pointers). After reset or a flush the RAM is cleared
// one address per cycle before requests are accepted.
//
// Ports:
//   Clk, Rst_n          rising-edge clock, synchronous active-low reset
//   Clr                 synchronous flush (honoured only while Ready)
//   Wr_req, Rd_req      push/enqueue and pop/dequeue requests
//   Datain              write data
//   Dataout, Dout_valid read data (from Ram_dat_i) and its valid strobe
//   Wr_ack, Rd_ack      same-cycle acceptance of the requests
//   Full, Empty, Count  occupancy status
//   Ovf, Udf            sticky overflow/underflow flags
//   Ready               high once the RAM clear sequence has finished
//   Ram_*               RAM port; Ram_dat_i valid one cycle after Ram_re
module xifo_ctrl #(
    parameter int MODE       = 0,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 1 << ADDR_WIDTH,
    parameter int SIZE       = 8
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Clr,
    input  logic                  Wr_req,
    input  logic                  Rd_req,
    input  logic [SIZE-1:0]       Datain,
    output logic [SIZE-1:0]       Dataout,
    output logic                  Dout_valid,
    output logic                  Wr_ack,
    output logic                  Rd_ack,
    output logic                  Full,
    output logic                  Empty,
    output logic [ADDR_WIDTH:0]   Count,
    output logic                  Ovf,
    output logic                  Udf,
    output logic                  Ready,
    output logic                  Ram_we,
    output logic                  Ram_re,
    output logic [ADDR_WIDTH-1:0] Ram_wr_adr,
    output logic [ADDR_WIDTH-1:0] Ram_rd_adr,
    output logic [SIZE-1:0]       Ram_dat_o,
    input  logic [SIZE-1:0]       Ram_dat_i
);

    localparam logic                  IS_STACK = (MODE == 0);
    localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] init_cnt, init_cnt_nxt;
    logic [ADDR_WIDTH-1:0] sp, sp_nxt;
    logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_nxt;
    logic [ADDR_WIDTH-1:0] rd_ptr, rd_ptr_nxt;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic                  ovf_nxt, udf_nxt;

    // Pointer arithmetic modulo DEPTH (DEPTH need not be a power of two).
    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST_ADR) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] ptr_dec(input logic [ADDR_WIDTH-1:0] p);
        return (p == '0) ? LAST_ADR : p - ADDR_WIDTH'(1);
    endfunction

    // Handshake, status and RAM port decode.
    always_comb begin
        Ready   = (state == RUN);
        Full    = (Count == DEPTH_C);
        Empty   = (Count == '0);
        // A flush cycle accepts nothing.
        Rd_ack  = Rd_req & Ready & ~Empty & ~Clr;
        // In stack mode a simultaneous pop wins over the push.
        Wr_ack  = Wr_req & Ready & ~Full & ~Clr & ~(IS_STACK & Rd_ack);
        Ram_re  = Rd_ack;
        Ram_we  = Ready ? Wr_ack : 1'b1;
        Ram_dat_o = Ready ? Datain : '0;
        if (!Ready)
            Ram_wr_adr = init_cnt;
        else if (IS_STACK)
            Ram_wr_adr = sp;
        else
            Ram_wr_adr = wr_ptr;
        Ram_rd_adr = IS_STACK ? ptr_dec(sp) : rd_ptr;
        Dataout    = Ram_dat_i;
    end

    // Next-state logic for the FSM, pointers, occupancy and error flags.
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        sp_nxt       = sp;
        wr_ptr_nxt   = wr_ptr;
        rd_ptr_nxt   = rd_ptr;
        count_nxt    = Count;
        ovf_nxt      = Ovf;
        udf_nxt      = Udf;

        case (state)
            INIT: begin
                init_cnt_nxt = ptr_inc(init_cnt);
                if (init_cnt == LAST_ADR)
                    state_nxt = RUN;
            end

            RUN: begin
                if (Clr) begin
                    state_nxt    = INIT;
                    init_cnt_nxt = '0;
                    sp_nxt       = '0;
                    wr_ptr_nxt   = '0;
                    rd_ptr_nxt   = '0;
                    count_nxt    = '0;
                    ovf_nxt      = 1'b0;
                    udf_nxt      = 1'b0;
                end else begin
                    if (IS_STACK) begin
                        // Push and pop are mutually exclusive here.
                        if (Wr_ack)
                            sp_nxt = ptr_inc(sp);
                        else if (Rd_ack)
                            sp_nxt = ptr_dec(sp);
                    end else begin
                        if (Wr_ack)
                            wr_ptr_nxt = ptr_inc(wr_ptr);
                        if (Rd_ack)
                            rd_ptr_nxt = ptr_inc(rd_ptr);
                    end
                    count_nxt = Count + (ADDR_WIDTH+1)'(Wr_ack) - (ADDR_WIDTH+1)'(Rd_ack);
                    // A full stack whose pop is served is not an overflow.
                    ovf_nxt   = Ovf | (Wr_req & Full & ~(IS_STACK & Rd_ack));
                    udf_nxt   = Udf | (Rd_req & Empty);
                end
            end

            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state      <= INIT;
            init_cnt   <= '0;
            sp         <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            Count      <= '0;
            Ovf        <= 1'b0;
            Udf        <= 1'b0;
            Dout_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            init_cnt   <= init_cnt_nxt;
            sp         <= sp_nxt;
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            Count      <= count_nxt;
            Ovf        <= ovf_nxt;
            Udf        <= udf_nxt;
            Dout_valid <= Rd_ack;
        end
    end

endmodule

// File: tb/tb_xifo_ctrl.sv
// Bench for xifo_ctrl: a stack instance (index 0) and a queue instance
// (index 1) share the same stimulus, each with its own registered-read RAM.
// A storage-level model (plain array used as a LIFO or FIFO) predicts every
// output each cycle; directed literal checks pin the model.
module tb_xifo_ctrl;

    logic       Clk = 1'b0;
    logic       Rst_n, Clr, Wr_req, Rd_req;
    logic [7:0] Datain;

    logic [7:0] dout [2];
    logic [7:0] dato [2];
    logic [7:0] rdat [2];
    logic       dv [2], wack [2], rack [2], full [2], empty [2];
    logic       ovf [2], udf [2], ready [2], we [2], re [2];
    logic [3:0] cnt [2];
    logic [2:0] wadr [2], radr [2];

    logic [7:0] mem [2][8];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 Clk = ~Clk;

    xifo_ctrl #(.MODE(0), .ADDR_WIDTH(3), .DEPTH(8), .SIZE(8)) u_stack (
        .Clk(Clk), .Rst_n(Rst_n), .Clr(Clr), .Wr_req(Wr_req), .Rd_req(Rd_req),
        .Datain(Datain), .Dataout(dout[0]), .Dout_valid(dv[0]),
        .Wr_ack(wack[0]), .Rd_ack(rack[0]), .Full(full[0]), .Empty(empty[0]),
        .Count(cnt[0]), .Ovf(ovf[0]), .Udf(udf[0]), .Ready(ready[0]),
        .Ram_we(we[0]), .Ram_re(re[0]), .Ram_wr_adr(wadr[0]), .Ram_rd_adr(radr[0]),
        .Ram_dat_o(dato[0]), .Ram_dat_i(rdat[0])
    );

    xifo_ctrl #(.MODE(1), .ADDR_WIDTH(3), .DEPTH(8), .SIZE(8)) u_queue (
        .Clk(Clk), .Rst_n(Rst_n), .Clr(Clr), .Wr_req(Wr_req), .Rd_req(Rd_req),
        .Datain(Datain), .Dataout(dout[1]), .Dout_valid(dv[1]),
        .Wr_ack(wack[1]), .Rd_ack(rack[1]), .Full(full[1]), .Empty(empty[1]),
        .Count(cnt[1]), .Ovf(ovf[1]), .Udf(udf[1]), .Ready(ready[1]),
        .Ram_we(we[1]), .Ram_re(re[1]), .Ram_wr_adr(wadr[1]), .Ram_rd_adr(radr[1]),
        .Ram_dat_o(dato[1]), .Ram_dat_i(rdat[1])
    );

    // RAM with registered read.
    always @(posedge Clk) begin
        for (int i = 0; i < 2; i++) begin
            if (we[i]) mem[i][wadr[i]] <= dato[i];
            if (re[i]) rdat[i] <= mem[i][radr[i]];
        end
    end

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, inst, act, exp, $time);
    endtask

    // Model state: values that hold after the most recent rising edge.
    int         m_init [2];
    int         m_cnt [2];
    logic       m_ovf [2], m_udf [2], m_dv [2];
    logic [7:0] m_dout [2];
    logic [7:0] m_store [2][8];
    bit         m_valid = 1'b0;

    always @(negedge Clk) begin : model
        logic e_ready, e_full, e_empty, e_rack, e_wack;
        for (int i = 0; i < 2; i++) begin
            e_ready = (m_init[i] == 0);
            e_full  = (m_cnt[i] == 8);
            e_empty = (m_cnt[i] == 0);
            e_rack  = Rd_req && e_ready && !e_empty && !Clr;
            e_wack  = Wr_req && e_ready && !e_full && !Clr && !(i == 0 && e_rack);

            if (m_valid) begin
                chk("ready", i, ready[i], e_ready);
                chk("full", i, full[i], e_full);
                chk("empty", i, empty[i], e_empty);
                chk("count", i, cnt[i], m_cnt[i]);
                chk("ovf", i, ovf[i], m_ovf[i]);
                chk("udf", i, udf[i], m_udf[i]);
                chk("rd_ack", i, rack[i], e_rack);
                chk("wr_ack", i, wack[i], e_wack);
                chk("ram_re", i, re[i], e_rack);
                chk("ram_we", i, we[i], e_ready ? e_wack : 1'b1);
                chk("dout_valid", i, dv[i], m_dv[i]);
                if (m_dv[i])
                    chk("dataout", i, dout[i], m_dout[i]);
                if (!e_ready) begin
                    chk("init_adr", i, wadr[i], 8 - m_init[i]);
                    chk("init_dat", i, dato[i], 0);
                end else if (e_wack) begin
                    chk("wr_dat", i, dato[i], Datain);
                end
            end

            if (!Rst_n) begin
                m_init[i] = 8;
                m_cnt[i]  = 0;
                m_ovf[i]  = 1'b0;
                m_udf[i]  = 1'b0;
                m_dv[i]   = 1'b0;
            end else begin
                m_dv[i] = e_rack;
                if (!e_ready) begin
                    m_init[i]--;
                end else if (Clr) begin
                    m_init[i] = 8;
                    m_cnt[i]  = 0;
                    m_ovf[i]  = 1'b0;
                    m_udf[i]  = 1'b0;
                end else begin
                    if (Wr_req && e_full && !(i == 0 && e_rack)) m_ovf[i] = 1'b1;
                    if (Rd_req && e_empty) m_udf[i] = 1'b1;
                    if (e_rack) begin
                        if (i == 1) begin
                            m_dout[i] = m_store[i][0];
                            for (int k = 0; k < 7; k++) m_store[i][k] = m_store[i][k+1];
                        end else begin
                            m_dout[i] = m_store[i][m_cnt[i]-1];
                        end
                        m_cnt[i]--;
                    end
                    if (e_wack) begin
                        m_store[i][m_cnt[i]] = Datain;
                        m_cnt[i]++;
                    end
                end
            end
        end
        if (!Rst_n) m_valid = 1'b1;
    end

    task automatic drive(input logic rst_n, input logic clr, input logic wr, input logic rd, input logic [7:0] d);
        Rst_n  = rst_n;
        Clr    = clr;
        Wr_req = wr;
        Rd_req = rd;
        Datain = d;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic step(input logic rst_n, input logic clr, input logic wr, input logic rd, input logic [7:0] d);
        drive(rst_n, clr, wr, rd, d);
        tick();
    endtask

    initial begin
        // Reset and RAM clear
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (3) tick();
        chk("lit_rst_ready", 1, ready[1], 0);
        chk("lit_rst_count", 1, cnt[1], 0);
        chk("lit_rst_dv", 1, dv[1], 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (7) tick();
        chk("lit_init_ready7", 1, ready[1], 0);
        tick();
        chk("lit_init_ready8", 1, ready[1], 1);
        chk("lit_init_empty", 1, empty[1], 1);

        // Queue order (stack sees the same pushes and pops in reverse)
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h22);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h33);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("lit_q_rd1", 1, dout[1], 8'h11);
        chk("lit_q_dv1", 1, dv[1], 1);
        chk("lit_s_rd1", 0, dout[0], 8'h33);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("lit_q_rd2", 1, dout[1], 8'h22);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("lit_q_rd3", 1, dout[1], 8'h33);
        chk("lit_s_rd3", 0, dout[0], 8'h11);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("lit_q_empty", 1, empty[1], 1);
        chk("lit_q_dv_off", 1, dv[1], 0);

        // Stack order and underflow
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'hA1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'hB2);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("lit_s_pop1", 0, dout[0], 8'hB2);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("lit_s_pop2", 0, dout[0], 8'hA1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        #2;
        chk("lit_s_udf_rack", 0, rack[0], 0);
        tick();
        chk("lit_s_udf", 0, udf[0], 1);

        // Fill, overflow, read-beats-write when full
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'h40 + 8'(k));
        chk("lit_q_full", 1, full[1], 1);
        chk("lit_q_cnt8", 1, cnt[1], 8);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'hEE);
        #2;
        chk("lit_q_ovf_wack", 1, wack[1], 0);
        tick();
        chk("lit_q_ovf", 1, ovf[1], 1);
        chk("lit_q_ovf_cnt", 1, cnt[1], 8);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 8'hEF);
        #2;
        chk("lit_q_full_rack", 1, rack[1], 1);
        chk("lit_q_full_wack", 1, wack[1], 0);
        tick();
        chk("lit_q_cnt7", 1, cnt[1], 7);
        chk("lit_q_full_dout", 1, dout[1], 8'h40);
        chk("lit_s_full_dout", 0, dout[0], 8'h47);

        // Down to four, then 20 cycles of simultaneous traffic
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("lit_q_cnt4", 1, cnt[1], 4);
        for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 1'b1, 1'b1, 8'h80 + 8'(k));
        chk("lit_q_wrap_cnt", 1, cnt[1], 4);
        chk("lit_q_wrap_dout", 1, dout[1], 8'h8F);
        chk("lit_s_mix_cnt", 0, cnt[0], 0);
        chk("lit_s_mix_dout", 0, dout[0], 8'h92);

        // Flush at Count=5
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'hC5);
        chk("lit_q_cnt5", 1, cnt[1], 5);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'hC6);
        chk("lit_clr_cnt", 1, cnt[1], 0);
        chk("lit_clr_ovf", 1, ovf[1], 0);
        chk("lit_clr_udf", 0, udf[0], 0);
        chk("lit_clr_ready", 1, ready[1], 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (7) tick();
        chk("lit_clr_ready7", 1, ready[1], 0);
        tick();
        chk("lit_clr_ready8", 1, ready[1], 1);

        // Reset in the middle of the clear sequence
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("lit_mid_init_adr", 1, wadr[1], 3);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("lit_rst_init_adr", 1, wadr[1], 0);
        chk("lit_rst_init_we", 1, we[1], 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (8) tick();
        chk("lit_rerun_ready", 1, ready[1], 1);

        // Reset alongside an accepted read clears the pending valid
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h5A);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("lit_rst_rd_dv", 1, dv[1], 0);
        chk("lit_rst_rd_cnt", 1, cnt[1], 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (9) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
